fetch_sequencer: RTL

Sequencing controller for the instruction-fetch side of the CPU. It owns the program counter and chooses each cycle between PC+4, a PC-relative conditional/unconditional branch target, and a register (BR) target. It also honours stall and halt requests and tells the downstream pipeline registers when to flush wrong-path instructions. It sits between the hazard/branch-resolution logic and `instructmem`, and it drives `instructmem.address` directly.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the instruction-fetch program counter. Each cycle it picks the next PC
// from a BR register target, a B/BL target, a taken conditional-branch
// target, the held PC (stall) or PC+4. Handles halt and boot, raises flush
// when a resolved branch redirects fetch, and keeps a sticky misalignment
// flag and a count of PC advances.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   stall        in   hold PC (load-use hazard)
//   halt         in   stop fetching until reset
//   br_valid     in   a branch resolves this cycle
//   br_taken     in   conditional branch outcome
//   uncond_br    in   resolved branch is B/BL (imm26 target)
//   br_reg       in   resolved branch is BR (reg_target)
//   br_pc        in   PC of the resolving branch
//   imm19        in   conditional branch word offset
//   imm26        in   unconditional branch word offset
//   reg_target   in   register value for BR
//   pc           out  current fetch address (registered)
//   fetch_valid  out  instruction at pc is a real fetch
//   flush        out  combinational; kill IF/ID and ID/EX at next edge
//   misalign     out  sticky; a BR target had nonzero low bits
//   fetch_count  out  number of PC advances since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        uncond_br,
    input  logic        br_reg,
    input  logic [63:0] br_pc,
    input  logic [18:0] imm19,
    input  logic [25:0] imm26,
    input  logic [63:0] reg_target,
    output logic [63:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic        fetch_valid_reg, fetch_valid_next;
    logic        misalign_reg, misalign_next;
    logic [31:0] fetch_count_reg, fetch_count_next;

    logic        redirect;
    logic [63:0] offset26;
    logic [63:0] offset19;

    // Sign-extended word offsets, already scaled by 4.
    assign offset26 = {{36{imm26[25]}}, imm26, 2'b00};
    assign offset19 = {{43{imm19[18]}}, imm19, 2'b00};

    assign redirect = br_valid & (br_reg | uncond_br | br_taken);
    assign flush    = (state_reg == ST_RUN) & redirect;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fetch_valid_next = fetch_valid_reg;
        misalign_next    = misalign_reg;
        fetch_count_next = fetch_count_reg;

        case (state_reg)
            ST_BOOT: begin
                state_next       = ST_RUN;
                fetch_valid_next = 1'b1;
            end
            ST_RUN: begin
                // A redirect wins over halt and stall: whatever raised them
                // is on the wrong path.
                if (br_valid && br_reg) begin
                    pc_next          = {reg_target[63:2], 2'b00};
                    misalign_next    = misalign_reg | (|reg_target[1:0]);
                    fetch_count_next = fetch_count_reg + 32'd1;
                end else if (br_valid && uncond_br) begin
                    pc_next          = br_pc + offset26;
                    fetch_count_next = fetch_count_reg + 32'd1;
                end else if (br_valid && br_taken) begin
                    pc_next          = br_pc + offset19;
                    fetch_count_next = fetch_count_reg + 32'd1;
                end else if (halt) begin
                    state_next       = ST_HALT;
                    fetch_valid_next = 1'b0;
                end else if (!stall) begin
                    pc_next          = pc_reg + 64'd4;
                    fetch_count_next = fetch_count_reg + 32'd1;
                end
            end
            ST_HALT: begin
                fetch_valid_next = 1'b0;
            end
            default: begin
                state_next       = ST_BOOT;
                pc_next          = RESET_PC;
                fetch_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_valid_reg <= 1'b0;
            misalign_reg    <= 1'b0;
            fetch_count_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_valid_reg <= fetch_valid_next;
            misalign_reg    <= misalign_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    assign pc          = pc_reg;
    assign fetch_valid = fetch_valid_reg;
    assign misalign    = misalign_reg;
    assign fetch_count = fetch_count_reg;

endmodule
